uart_atx: RTL and testbench
===========================

Name: uart_atx

Overview:
- Byte-serial UART transmitter that consumes the CPU's atx_data / atx_load output words and returns the atx_busy status word polled by the putchar routine.
- Frame format is 8N1, LSB first, on a single output pin.
- Level handshake: the CPU writes a byte, holds load high until busy is seen, then drops load.
- The block must send exactly one frame per load assertion, however long load is held.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit time (50 MHz / 115200 baud); legal range 4..65535.
- CNT_W, 16, width of the bit-time counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- data  input  8  byte to send (low byte of the atx_data register).
- load  input  1  level request from CPU output word atx_load.
- busy  output  1  high while a frame is in flight (feeds atx_busy, bit 0).
- txd  output  1  serial line; idles high.

Behaviour:
Reset:
- Synchronous: on any clk edge with reset high, go to IDLE.
- txd=1, busy=0, armed=1, counters cleared.
- Applies mid-frame: the frame is abandoned and txd returns high on the next edge.

Internal state:
- State register: IDLE, START, DATA, STOP.
- Bit-time counter cnt (CNT_W bits), 3-bit bit index bidx, 8-bit shift register sh.
- armed flag.

State transitions:
- IDLE:
  - txd=1, busy=0.
  - If load=1 and armed=1 at an edge: sh<=data, cnt<=0, armed<=0, busy<=1, state<=START.
  - If load=0: armed<=1.
  - Latency: busy rises one cycle after load is sampled high; first txd low appears the same cycle.
- START:
  - txd=0 for exactly CLKS_PER_BIT cycles.
  - When cnt==CLKS_PER_BIT-1: cnt<=0, bidx<=0, state<=DATA.
- DATA:
  - txd=sh[0].
  - At each bit-time end: sh<=sh>>1, bidx<=bidx+1.
  - After the bit with bidx==7 ends: state<=STOP.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - At end: busy<=0, state<=IDLE.

Timing:
- Frame length is exactly 10*CLKS_PER_BIT cycles from first txd low to busy low.
- busy stays high through the full stop bit.

Re-arm rule:
- armed is cleared on frame start and set only by sampling load=0 (in any state).
- If load is still high when STOP ends, no new frame starts until load has been seen low for at least one cycle.
- This prevents double sends when the CPU is slow to drop load.

Data capture:
- data is captured only at the frame-start edge.
- Changes to data during a frame have no effect on the frame in flight.

Other boundaries:
- load pulses while busy=1 are ignored, apart from re-arming via load=0.
- A one-cycle load pulse in IDLE (with armed=1) starts a full frame.
- reset and load high in the same cycle: reset wins; armed=1 afterwards, so a frame starts on the next edge if load is still high.

Arithmetic:
- cnt increments modulo the compare only; no wrap beyond CLKS_PER_BIT-1.
- bidx is 3 bits and wraps 7->0 on entering STOP (value unused).

Test Plan:
- Reset then idle, CLKS_PER_BIT=4 -> txd=1 and busy=0 for 100 cycles; no transitions on txd.
- data=0x55, load held high until busy, then low -> busy rises 1 cycle after load is sampled. txd sequence, one level per 4-cycle bit, is 0,1,0,1,0,1,0,1,0,1 (start bit, then LSB-first data, then stop). busy falls after exactly 40 cycles.
- data=0x41, load held high for 200 cycles -> exactly one frame (0,1,0,0,0,0,0,1,0,1). No second start bit until load drops, then re-rises; a second frame then follows.
- data changed from 0xAA to 0x0D mid-frame -> serialized byte is still 0xAA. A frame issued after re-arm carries 0x0D.
- reset asserted during DATA bit 3 -> the next edge gives txd=1 and busy=0. A new load then produces a full, correct 10-bit frame.
- Back-to-back putchar emulation sending 0x55,0xAA,0x41,0x42,0x0D,0x0A, each waiting for busy=0 and then handshaking as the CPU does -> the line decoder receives all six bytes in order, with no gaps shorter than one stop bit.

Source files
------------

// File: rtl/uart_atx_if.sv
// CPU-side handshake (data/load/busy) and serial line of the uart_atx transmitter.
// The CPU is the master; the transmitter takes the slave modport.
interface uart_atx_if;
  logic [7:0] data;
  logic       load;
  logic       busy;
  logic       txd;

  modport master (output data, output load, input busy, input txd);
  modport slave  (input data, input load, output busy, output txd);
endinterface

// File: rtl/uart_atx.sv
// 8N1 LSB-first UART transmitter driven by a level load/busy handshake.
// One frame per load assertion: load must be seen low before another frame can start.
module uart_atx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_atx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bidx;
  logic [7:0]       r_sh;
  logic             r_armed;
  logic             r_busy;
  logic             r_txd;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [2:0]       w_bidx;
  logic [7:0]       w_sh;
  logic             w_armed;
  logic             w_busy;
  logic             w_txd;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign bus.busy  = r_busy;
  assign bus.txd   = r_txd;

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_bidx  <= 3'd0;
      r_sh    <= 8'h00;
      r_armed <= 1'b1;
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bidx  <= w_bidx;
      r_sh    <= w_sh;
      r_armed <= w_armed;
      r_busy  <= w_busy;
      r_txd   <= w_txd;
    end
  end

  // Next-state logic; txd is computed from the next state so the line is registered.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bidx  = r_bidx;
    w_sh    = r_sh;
    w_busy  = r_busy;
    // Seeing load low re-arms in every state; only a frame start clears it.
    w_armed = bus.load ? r_armed : 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_cnt  = CNT_ZERO;
        w_busy = 1'b0;
        if (bus.load && r_armed) begin
          w_sh    = bus.data;
          w_armed = 1'b0;
          w_busy  = 1'b1;
          w_state = ST_START;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_cnt   = CNT_ZERO;
          w_bidx  = 3'd0;
          w_state = ST_DATA;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt  = CNT_ZERO;
          w_sh   = {1'b0, r_sh[7:1]};
          w_bidx = r_bidx + 3'd1;
          if (r_bidx == 3'd7) begin
            w_state = ST_STOP;
          end else begin
            w_state = ST_DATA;
          end
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt   = CNT_ZERO;
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = CNT_ZERO;
        w_busy  = 1'b0;
      end
    endcase

    case (w_state)
      ST_START: w_txd = 1'b0;
      ST_DATA:  w_txd = w_sh[0];
      default:  w_txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_atx.sv
// Self-checking bench for uart_atx: expected line levels come from the 8N1 frame
// definition ({stop, data, start} bit k held for N cycles), plus a serial line decoder.
module tb_uart_atx;

  localparam int N = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_atx_if u_if();

  uart_atx #(.CLKS_PER_BIT(N), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line decoder: finds start bits, samples mid-bit, records bytes and idle-gap violations.
  bit         dec_en;
  logic       dec_active;
  int         dec_c;
  int         hi_run;
  int         gap_err;
  int         frame_err;
  logic [9:0] dec_bits;
  logic [7:0] rx_q[$];

  initial begin
    dec_active = 1'b0;
    dec_c      = 0;
    hi_run     = N;
    dec_bits   = 10'd0;
    forever begin
      @(negedge clk);
      if (!dec_en) begin
        dec_active = 1'b0;
        hi_run     = N;
      end else if (!dec_active) begin
        if (u_if.txd === 1'b0) begin
          dec_active = 1'b1;
          dec_c      = 0;
          if (hi_run < N) gap_err++;
        end else begin
          hi_run++;
        end
      end else begin
        dec_c++;
      end
      if (dec_en && dec_active && (dec_c % N) == N / 2) begin
        dec_bits[dec_c / N] = u_if.txd;
        if (dec_c / N == 9) begin
          if (dec_bits[0] !== 1'b0 || dec_bits[9] !== 1'b1) frame_err++;
          rx_q.push_back(dec_bits[8:1]);
          dec_active = 1'b0;
          hi_run     = N / 2 + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (u_if.txd !== 1'b1) begin
      errors++;
      $display("FAIL %s txd got %b want 1", tag, u_if.txd);
    end
    checks++;
    if (u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got %b want 0", tag, u_if.busy);
    end
  endtask

  // Starts a frame (load rises now), holds load until cycle 'hold' after the start
  // edge, optionally changes data at cycle 'mid_at', and checks every line cycle.
  task automatic run_frame(input logic [7:0] d, input int hold,
                           input logic [7:0] d_mid, input int mid_at, input string tag);
    logic [9:0] fr;
    logic       exp_txd;
    logic       exp_busy;
    int         last;
    fr   = {1'b1, d, 1'b0};
    last = (hold > 10 * N) ? hold : 10 * N;
    u_if.data = d;
    u_if.load = 1'b1;
    tick();
    for (int k = 0; k <= last; k++) begin
      exp_txd  = (k < 10 * N) ? fr[k / N] : 1'b1;
      exp_busy = (k < 10 * N) ? 1'b1 : 1'b0;
      checks++;
      if (u_if.txd !== exp_txd) begin
        errors++;
        $display("FAIL %s txd cycle %0d got %b want %b", tag, k, u_if.txd, exp_txd);
      end
      checks++;
      if (u_if.busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b want %b", tag, k, u_if.busy, exp_busy);
      end
      if (k == hold) u_if.load = 1'b0;
      if (k == mid_at) u_if.data = d_mid;
      tick();
    end
    u_if.load = 1'b0;
    check_idle({tag, "_end"});
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (u_if.busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy wait timeout got %b want 0", tag, u_if.busy);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    u_if.load = 1'b0;
    u_if.data = 8'h00;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_idle("idle100");
    end
    // Reset and load together: reset wins, frame begins on the following edge.
    reset     = 1'b1;
    u_if.load = 1'b1;
    u_if.data = 8'h3C;
    tick();
    check_idle("reset_wins");
    reset = 1'b0;
    run_frame(8'h3C, 0, 8'h3C, -1, "after_reset_load");
  endtask

  task automatic test_basic();
    run_frame(8'h55, 0, 8'h55, -1, "basic55");
  endtask

  task automatic test_long_load();
    run_frame(8'h41, 200, 8'h41, -1, "hold41");
    tick();
    check_idle("hold41_gap");
    run_frame(8'h41, 0, 8'h41, -1, "hold41_second");
  endtask

  task automatic test_data_change();
    run_frame(8'hAA, 0, 8'h0D, 17, "chgAA");
    run_frame(8'h0D, 0, 8'h0D, -1, "chg0D");
  endtask

  task automatic test_mid_reset();
    logic [9:0] fr;
    fr = {1'b1, 8'hC3, 1'b0};
    u_if.data = 8'hC3;
    u_if.load = 1'b1;
    tick();
    u_if.load = 1'b0;
    for (int k = 0; k < 4 * N + 1; k++) begin
      checks++;
      if (u_if.txd !== fr[k / N]) begin
        errors++;
        $display("FAIL midrst_pre txd cycle %0d got %b want %b", k, u_if.txd, fr[k / N]);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    check_idle("midrst");
    reset = 1'b0;
    tick();
    check_idle("midrst_after");
    run_frame(8'h96, 0, 8'h96, -1, "midrst_new");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] dm;
    int         hold;
    int         mid;
    int         gap;
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      dm   = 8'($urandom);
      hold = $urandom_range(0, 60);
      mid  = $urandom_range(0, 45);
      gap  = $urandom_range(0, 5);
      run_frame(d, hold, dm, mid, "rand");
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle("rand_gap");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[6];
    msg = '{8'h55, 8'hAA, 8'h41, 8'h42, 8'h0D, 8'h0A};
    rx_q.delete();
    gap_err   = 0;
    frame_err = 0;
    dec_en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_idle(20 * N, "b2b");
      run_frame(msg[i], 0, msg[i], -1, "b2b");
    end
    for (int i = 0; i < 2 * N; i++) tick();
    dec_en = 1'b0;
    checks++;
    if (rx_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", rx_q.size());
    end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== msg[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d got %h want %h", i, rx_q[i], msg[i]);
      end
    end
    checks++;
    if (gap_err != 0) begin
      errors++;
      $display("FAIL b2b_gap got %0d short gaps want 0", gap_err);
    end
    checks++;
    if (frame_err != 0) begin
      errors++;
      $display("FAIL b2b_framing got %0d bad frames want 0", frame_err);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    dec_en    = 1'b0;
    gap_err   = 0;
    frame_err = 0;
    reset     = 1'b1;
    u_if.load = 1'b0;
    u_if.data = 8'h00;
    test_reset();
    test_basic();
    test_long_load();
    test_data_change();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
